// File: rtl/cic_decim_sequencer.sv
// Strobe-based sequencer for the CIC decimator: clear, settle, then decimated
// samples handed downstream through a one-entry valid/ready register.
module cic_decim_sequencer #(
  parameter int STAGES = 3,
  parameter int RATE_W = 4,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  input  logic              cfg_load,
  output logic              integ_en,
  output logic              comb_clear,
  output logic              comb_strobe,
  input  logic [DATA_W-1:0] comb_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int SW = $clog2(STAGES + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SETTLE, RUN} state_t;

  state_t            state;
  logic [RATE_W-1:0] ctr;
  logic [RATE_W-1:0] active_rate;
  logic [SW-1:0]     settle_cnt;
  logic              counting;
  logic              hit;

  assign counting    = (state == SETTLE) || (state == RUN);
  assign hit         = (ctr == active_rate);
  assign integ_en    = counting;
  assign comb_clear  = (state == CLEAR);
  // A strobe only fires in a cycle that stays in the running sequence.
  assign comb_strobe = counting && enable && !cfg_load && hit;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ctr         <= '0;
      settle_cnt  <= '0;
      active_rate <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= CLEAR;
        end
        CLEAR: begin
          active_rate <= rate;
          ctr         <= '0;
          settle_cnt  <= '0;
          out_valid   <= 1'b0;
          overrun     <= 1'b0;
          state       <= SETTLE;
        end
        SETTLE, RUN: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (!enable) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end else if (cfg_load) begin
            state <= CLEAR;
          end else begin
            ctr <= hit ? '0 : ctr + 1'b1;
            if (hit) begin
              if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
                if (settle_cnt == SW'(STAGES - 1)) state <= RUN;
              end else begin
                out_data  <= comb_data;
                out_valid <= 1'b1;
                // Newest sample wins; flag the one that was never consumed.
                if (out_valid && !out_ready) overrun <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_decim_sequencer.sv
// Directed bench for cic_decim_sequencer; delivered samples checked by a
// queue-based scoreboard on every valid/ready transfer.
module tb_cic_decim_sequencer;
  localparam int RATE_W = 4;
  localparam int DATA_W = 7;

  logic              clk = 1'b0;
  logic              rst_n, enable, cfg_load, out_ready;
  logic [RATE_W-1:0] rate;
  logic [DATA_W-1:0] comb_data;
  logic              integ_en, comb_clear, comb_strobe, out_valid, overrun, busy;
  logic [DATA_W-1:0] out_data;

  int tests = 0;
  int failed = 0;
  logic [DATA_W-1:0] sb[$];

  cic_decim_sequencer #(.STAGES(3), .RATE_W(RATE_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rate(rate), .cfg_load(cfg_load),
    .integ_en(integ_en), .comb_clear(comb_clear), .comb_strobe(comb_strobe),
    .comb_data(comb_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every transfer must deliver the next expected sample.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL sb_unexpected: got %0h expected no transfer at %0t", out_data, $time);
      end else begin
        logic [DATA_W-1:0] e;
        e = sb.pop_front();
        if (out_data !== e) begin
          failed++;
          $display("FAIL sb_data: got %0h expected %0h at %0t", out_data, e, $time);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_integ_en"}, integ_en, 0);
    chk({tag, "_comb_clear"}, comb_clear, 0);
    chk({tag, "_comb_strobe"}, comb_strobe, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; rate = '0; cfg_load = 1'b0;
    out_ready = 1'b0; comb_data = '0;
    cyc(); cyc();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // R=4, ready high: three discarded strobes, capture at c+16
    enable = 1'b1; rate = 4'd3; out_ready = 1'b1;
    cyc(); #1;
    chk("t1_clear", comb_clear, 1);
    chk("t1_clear_integ", integ_en, 0);
    chk("t1_clear_busy", busy, 1);
    for (int k = 1; k <= 18; k++) begin
      cyc();
      comb_data = (k == 16) ? 7'h2A : 7'h00;
      if (k == 16) sb.push_back(7'h2A);
      #1;
      chk($sformatf("t1_strobe_%0d", k), comb_strobe, (k % 4 == 0));
      chk($sformatf("t1_clear_%0d", k), comb_clear, 0);
      chk($sformatf("t1_integ_%0d", k), integ_en, 1);
      chk($sformatf("t1_valid_%0d", k), out_valid, (k == 17));
      if (k == 17) chk("t1_data", out_data, 7'h2A);
    end
    enable = 1'b0;
    cyc(); #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_integ", integ_en, 0);
    chk("t1_idle_valid", out_valid, 0);

    // R=1: strobe every cycle, continuous valid, no overrun
    enable = 1'b1; rate = 4'd0;
    cyc();
    for (int k = 1; k <= 12; k++) begin
      cyc();
      comb_data = 7'(k + 'h40);
      if (k >= 4 && k < 12) sb.push_back(7'(k + 'h40));
      #1;
      chk($sformatf("t2_strobe_%0d", k), comb_strobe, 1);
      chk($sformatf("t2_valid_%0d", k), out_valid, (k >= 5));
      chk($sformatf("t2_overrun_%0d", k), overrun, 0);
      if (k >= 5) chk($sformatf("t2_data_%0d", k), out_data, k - 1 + 'h40);
    end
    enable = 1'b0;
    cyc(); #1;
    chk("t2_idle_valid", out_valid, 0);

    // R=4, ready low across two captures: newest wins, sticky overrun
    enable = 1'b1; rate = 4'd3; out_ready = 1'b0;
    cyc();
    for (int k = 1; k <= 21; k++) begin
      cyc();
      comb_data = (k == 16) ? 7'h11 : (k == 20) ? 7'h22 : 7'h00;
      if (k == 20) sb.push_back(7'h22);
      #1;
      if (k == 17) begin
        chk("t3_valid1", out_valid, 1);
        chk("t3_data1", out_data, 7'h11);
        chk("t3_overrun0", overrun, 0);
      end
      if (k == 21) begin
        chk("t3_valid2", out_valid, 1);
        chk("t3_data2", out_data, 7'h22);
        chk("t3_overrun1", overrun, 1);
      end
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    #1;
    chk("t3_drained", out_valid, 0);
    chk("t3_overrun_sticky", overrun, 1);
    for (int k = 23; k <= 25; k++) begin
      cyc();
      comb_data = (k == 24) ? 7'h33 : 7'h00;
      #1;
    end
    chk("t5_pre_valid", out_valid, 1);
    chk("t5_pre_overrun", overrun, 1);

    // cfg_load in RUN with rate=7: clear, three settle strobes at R=8
    cfg_load = 1'b1; rate = 4'd7;
    cyc();
    cfg_load = 1'b0;
    #1;
    chk("t5_clear", comb_clear, 1);
    for (int k = 1; k <= 33; k++) begin
      cyc();
      out_ready = 1'b1;
      comb_data = (k == 32) ? 7'h55 : 7'h00;
      if (k == 32) sb.push_back(7'h55);
      #1;
      chk($sformatf("t5_strobe_%0d", k), comb_strobe, (k % 8 == 0));
      if (k == 1) begin
        chk("t5_valid_cleared", out_valid, 0);
        chk("t5_overrun_cleared", overrun, 0);
        chk("t5_clear_once", comb_clear, 0);
      end
      if (k == 32) chk("t5_no_valid_before", out_valid, 0);
      if (k == 33) begin
        chk("t5_valid", out_valid, 1);
        chk("t5_data", out_data, 7'h55);
      end
    end
    enable = 1'b0;
    cyc(); #1;
    chk("t5_drop_busy", busy, 0);
    chk("t5_drop_integ", integ_en, 0);
    chk("t5_drop_valid", out_valid, 0);
    cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    #1;
    chk("t6_idle_cfg_busy", busy, 0);
    chk("t6_idle_cfg_clear", comb_clear, 0);

    // R=4, ready pulsed in the strobe cycle while valid
    enable = 1'b1; rate = 4'd3; out_ready = 1'b0;
    cyc();
    for (int k = 1; k <= 22; k++) begin
      cyc();
      out_ready = (k == 20 || k == 21);
      comb_data = (k == 16) ? 7'h61 : (k == 20) ? 7'h62 : 7'h00;
      if (k == 16 || k == 20) sb.push_back(comb_data);
      #1;
      if (k == 20) begin
        chk("t4_strobe", comb_strobe, 1);
        chk("t4_valid_before", out_valid, 1);
      end
      if (k == 21) begin
        chk("t4_valid_kept", out_valid, 1);
        chk("t4_data", out_data, 7'h62);
        chk("t4_no_overrun", overrun, 0);
      end
      if (k == 22) chk("t4_drained", out_valid, 0);
    end

    // one-cycle reset in SETTLE
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    cyc(); cyc(); cyc();
    #1;
    chk("t6_in_settle", integ_en, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; enable = 1'b0;
    #1;
    chk_reset_outputs("t6_rst");

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
